// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Clocked front-end that shares one combinational 4-bit ALU between two
//   requesters. The block arbitrates round-robin, drives and holds the ALU
//   operands and function bits for EXEC_CYCLES cycles, captures ALU_OUT, and
//   returns the result to the winning requester over a valid/ready channel.
//
// Parameters
//   EXEC_CYCLES  cycles the ALU inputs are held before alu_out is sampled (1..15)
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   reqN_valid/ready/op/x/y         request channel N (N = 0,1); op: 00 ADD,
//                                   01 SUB, 10 XOR, 11 XNOR
//   rspN_valid/ready/data           response channel N, data valid with valid
//   alu_x, alu_y, alu_f0, alu_f1    to the ALU operand and function inputs
//   alu_out                         from the ALU result
//   busy                            high while settling or responding
module alu_sequencer #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  logic [3:0] req0_x,
  input  logic [3:0] req0_y,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  logic [3:0] req1_x,
  input  logic [3:0] req1_y,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [3:0] rsp0_data,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [3:0] rsp1_data,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  output logic       alu_f0,
  output logic       alu_f1,
  input  logic [3:0] alu_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Counter load so that alu_out is sampled EXEC_CYCLES edges after accept.
  localparam logic [3:0] SETTLE_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state_r;
  logic       ptr_r;
  logic       owner_r;
  logic [3:0] cnt_r;
  logic [3:0] result_r;
  logic [3:0] alu_x_r;
  logic [3:0] alu_y_r;
  logic [1:0] alu_op_r;
  logic       rsp0_valid_r;
  logic       rsp1_valid_r;
  logic       busy_r;

  logic       grant0_s;
  logic       grant1_s;
  logic [1:0] sel_op_s;
  logic [3:0] sel_x_s;
  logic [3:0] sel_y_s;
  logic       rsp_ready_s;

  // Round-robin grant: the requester at ptr wins, else the other one if valid.
  // Depends only on state, ptr and the request valids.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_r == IDLE) begin
      if (ptr_r == 1'b0) begin
        grant0_s = req0_valid;
        grant1_s = ~req0_valid & req1_valid;
      end else begin
        grant1_s = req1_valid;
        grant0_s = ~req1_valid & req0_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Operand mux for the granted requester and the owner's response ready.
  always_comb begin
    sel_op_s    = req0_op;
    sel_x_s     = req0_x;
    sel_y_s     = req0_y;
    if (grant1_s) begin
      sel_op_s = req1_op;
      sel_x_s  = req1_x;
      sel_y_s  = req1_y;
    end else begin
      sel_op_s = req0_op;
      sel_x_s  = req0_x;
      sel_y_s  = req0_y;
    end
    rsp_ready_s = owner_r ? rsp1_ready : rsp0_ready;
  end

  // Sequencer FSM with registered ALU drive, response and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      ptr_r        <= 1'b0;
      owner_r      <= 1'b0;
      cnt_r        <= 4'd0;
      result_r     <= 4'd0;
      alu_x_r      <= 4'd0;
      alu_y_r      <= 4'd0;
      alu_op_r     <= 2'd0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant0_s || grant1_s) begin
            // ALU drive registers double as the captured request; they
            // change only here so the ALU inputs hold through SETTLE/RESP.
            alu_x_r  <= sel_x_s;
            alu_y_r  <= sel_y_s;
            alu_op_r <= sel_op_s;
            owner_r  <= grant1_s;
            cnt_r    <= SETTLE_LOAD;
            busy_r   <= 1'b1;
            state_r  <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_r == 4'd0) begin
            result_r     <= alu_out;
            rsp0_valid_r <= ~owner_r;
            rsp1_valid_r <= owner_r;
            state_r      <= RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready_s) begin
            ptr_r        <= ~owner_r;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            state_r      <= IDLE;
          end
        end
        default: begin
          rsp0_valid_r <= 1'b0;
          rsp1_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp0_data  = result_r;
  assign rsp1_data  = result_r;
  assign alu_x      = alu_x_r;
  assign alu_y      = alu_y_r;
  // Op encoding is already {F1,F0}.
  assign alu_f1     = alu_op_r[1];
  assign alu_f0     = alu_op_r[0];
  assign busy       = busy_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: instance a uses EXEC_CYCLES=1 with an
// ideal ALU, instance b uses EXEC_CYCLES=4 with an ALU that shows X for
// three cycles after its inputs change.
module tb_alu_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Instance a signals
  logic       a_req0_valid, a_req0_ready, a_req1_valid, a_req1_ready;
  logic [1:0] a_req0_op, a_req1_op;
  logic [3:0] a_req0_x, a_req0_y, a_req1_x, a_req1_y;
  logic       a_rsp0_valid, a_rsp0_ready, a_rsp1_valid, a_rsp1_ready;
  logic [3:0] a_rsp0_data, a_rsp1_data;
  logic [3:0] a_alu_x, a_alu_y, a_alu_out;
  logic       a_alu_f0, a_alu_f1, a_busy;

  // Instance b signals
  logic       b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
  logic [1:0] b_req0_op, b_req1_op;
  logic [3:0] b_req0_x, b_req0_y, b_req1_x, b_req1_y;
  logic       b_rsp0_valid, b_rsp0_ready, b_rsp1_valid, b_rsp1_ready;
  logic [3:0] b_rsp0_data, b_rsp1_data;
  logic [3:0] b_alu_x, b_alu_y, b_alu_out;
  logic       b_alu_f0, b_alu_f1, b_busy;

  alu_sequencer #(.EXEC_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_op(a_req0_op),
    .req0_x(a_req0_x), .req0_y(a_req0_y),
    .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_op(a_req1_op),
    .req1_x(a_req1_x), .req1_y(a_req1_y),
    .rsp0_valid(a_rsp0_valid), .rsp0_ready(a_rsp0_ready), .rsp0_data(a_rsp0_data),
    .rsp1_valid(a_rsp1_valid), .rsp1_ready(a_rsp1_ready), .rsp1_data(a_rsp1_data),
    .alu_x(a_alu_x), .alu_y(a_alu_y), .alu_f0(a_alu_f0), .alu_f1(a_alu_f1),
    .alu_out(a_alu_out), .busy(a_busy)
  );

  alu_sequencer #(.EXEC_CYCLES(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_op(b_req0_op),
    .req0_x(b_req0_x), .req0_y(b_req0_y),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_op(b_req1_op),
    .req1_x(b_req1_x), .req1_y(b_req1_y),
    .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready), .rsp0_data(b_rsp0_data),
    .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready), .rsp1_data(b_rsp1_data),
    .alu_x(b_alu_x), .alu_y(b_alu_y), .alu_f0(b_alu_f0), .alu_f1(b_alu_f1),
    .alu_out(b_alu_out), .busy(b_busy)
  );

  // Behaviour of the four_bit_alu: F1 selects XOR path, F0 subtracts/inverts Y.
  function automatic logic [3:0] alu_fn(input logic [3:0] x, input logic [3:0] y,
                                        input logic f1, input logic f0);
    if (f1) return f0 ? (x ^ ~y) : (x ^ y);
    else    return f0 ? (x - y) : (x + y);
  endfunction

  assign a_alu_out = alu_fn(a_alu_x, a_alu_y, a_alu_f1, a_alu_f0);

  // Slow ALU for instance b: unknown until inputs have been stable 3 cycles.
  logic [9:0] b_cur;
  logic [9:0] b_prev;
  int         b_stable;
  assign b_cur = {b_alu_x, b_alu_y, b_alu_f1, b_alu_f0};
  always @(posedge clk) begin
    if (b_cur !== b_prev) b_stable <= 1;
    else if (b_stable < 15) b_stable <= b_stable + 1;
    b_prev <= b_cur;
  end
  assign b_alu_out = (b_cur === b_prev && b_stable >= 3) ?
                     alu_fn(b_alu_x, b_alu_y, b_alu_f1, b_alu_f0) : 4'bxxxx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic own;
    checks = 0;
    errors = 0;
    b_stable = 0;
    rst_n = 1'b0;
    {a_req0_valid, a_req1_valid, a_rsp0_ready, a_rsp1_ready} = 4'b0000;
    {b_req0_valid, b_req1_valid, b_rsp0_ready, b_rsp1_ready} = 4'b0000;
    a_req0_op = 2'd0; a_req0_x = 4'd0; a_req0_y = 4'd0;
    a_req1_op = 2'd0; a_req1_x = 4'd0; a_req1_y = 4'd0;
    b_req0_op = 2'd0; b_req0_x = 4'd0; b_req0_y = 4'd0;
    b_req1_op = 2'd0; b_req1_x = 4'd0; b_req1_y = 4'd0;

    // Reset values
    #1;
    chk("rst_a_outs", {a_busy, a_rsp0_valid, a_rsp1_valid, a_req0_ready, a_req1_ready, a_alu_f1, a_alu_f0}, 8'h00);
    chk("rst_a_alu", {a_alu_x, a_alu_y}, 8'h00);
    chk("rst_a_data", {a_rsp0_data, a_rsp1_data}, 8'h00);
    chk("rst_b_outs", {b_busy, b_rsp0_valid, b_rsp1_valid, b_req0_ready, b_req1_ready, b_alu_f1, b_alu_f0}, 8'h00);
    chk("rst_b_alu", {b_alu_x, b_alu_y}, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ADD 5+3 on requester 0
    a_req0_valid = 1'b1; a_req0_op = 2'b00; a_req0_x = 4'd5; a_req0_y = 4'd3;
    a_rsp0_ready = 1'b1;
    #1;
    chk("add_ready", {a_req1_ready, a_req0_ready}, 8'h01);
    tick();
    a_req0_valid = 1'b0;
    chk("add_alu", {a_alu_x, a_alu_y}, 8'h53);
    chk("add_f", {a_alu_f1, a_alu_f0}, 8'h00);
    chk("add_busy_noready", {a_busy, a_req0_ready, a_rsp0_valid}, 8'h04);
    tick();
    chk("add_rsp_valid", {a_rsp1_valid, a_rsp0_valid}, 8'h01);
    chk("add_data", a_rsp0_data, 8'h08);
    tick();
    chk("add_done", {a_busy, a_rsp0_valid, a_rsp1_valid}, 8'h00);
    chk("add_alu_hold", {a_alu_x, a_alu_y}, 8'h53);

    // SUB 2-5 on requester 1 wraps to 0xD
    a_req1_valid = 1'b1; a_req1_op = 2'b01; a_req1_x = 4'd2; a_req1_y = 4'd5;
    a_rsp1_ready = 1'b1;
    #1;
    chk("sub_ready", {a_req1_ready, a_req0_ready}, 8'h02);
    tick();
    a_req1_valid = 1'b0;
    chk("sub_f", {a_alu_f1, a_alu_f0}, 8'h01);
    tick();
    chk("sub_rsp_valid", {a_rsp1_valid, a_rsp0_valid}, 8'h02);
    chk("sub_data", a_rsp1_data, 8'h0D);
    tick();

    // XNOR 0xA, 0x3 on requester 0
    a_req0_valid = 1'b1; a_req0_op = 2'b11; a_req0_x = 4'hA; a_req0_y = 4'h3;
    #1;
    chk("xnor_ready", {a_req1_ready, a_req0_ready}, 8'h01);
    tick();
    a_req0_valid = 1'b0;
    chk("xnor_f", {a_alu_f1, a_alu_f0}, 8'h03);
    tick();
    chk("xnor_data", {3'b000, a_rsp0_valid, a_rsp0_data}, 8'h16);
    tick();

    // Both requesters continuously valid from reset: strict alternation
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a_req0_valid = 1'b1; a_req0_op = 2'b10; a_req0_x = 4'hF; a_req0_y = 4'h1;
    a_req1_valid = 1'b1; a_req1_op = 2'b00; a_req1_x = 4'd7; a_req1_y = 4'd9;
    #1;
    for (int k = 0; k < 4; k++) begin
      own = k[0];
      chk("alt_grant", {a_req1_ready, a_req0_ready}, own ? 8'h02 : 8'h01);
      tick();
      chk("alt_settle_noready", {a_req1_ready, a_req0_ready}, 8'h00);
      tick();
      chk("alt_rsp_valid", {a_rsp1_valid, a_rsp0_valid}, own ? 8'h02 : 8'h01);
      chk("alt_data", own ? a_rsp1_data : a_rsp0_data, own ? 8'h00 : 8'h0E);
      tick();
    end
    a_req0_valid = 1'b0;
    a_req1_valid = 1'b0;

    // EXEC_CYCLES=4 with response backpressure; requester 1 waits
    b_req0_valid = 1'b1; b_req0_op = 2'b10; b_req0_x = 4'hC; b_req0_y = 4'h5;
    b_req1_valid = 1'b1; b_req1_op = 2'b01; b_req1_x = 4'h9; b_req1_y = 4'h4;
    #1;
    chk("b_grant0", {b_req1_ready, b_req0_ready}, 8'h01);
    tick();
    b_req0_valid = 1'b0;
    chk("b_alu0", {b_alu_x, b_alu_y}, 8'hC5);
    chk("b_f0", {b_alu_f1, b_alu_f0}, 8'h02);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("b_settle_hold", {b_alu_x, b_alu_y}, 8'hC5);
      chk("b_settle_flags", {b_busy, b_rsp0_valid, b_req1_ready, b_alu_f1, b_alu_f0}, 8'h12);
    end
    tick();
    chk("b_rsp0", {3'b000, b_rsp0_valid, b_rsp0_data}, 8'h19);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b_bp_hold", {3'b000, b_rsp0_valid, b_rsp0_data}, 8'h19);
      chk("b_bp_wait", {b_req1_ready, b_rsp1_valid}, 8'h00);
    end
    b_rsp0_ready = 1'b1;
    tick();
    chk("b_bp_done", {b_busy, b_rsp0_valid}, 8'h00);
    chk("b_grant1", {b_req1_ready, b_req0_ready}, 8'h02);
    chk("b_idle_hold", {b_alu_x, b_alu_y}, 8'hC5);
    tick();
    b_req1_valid = 1'b0;
    chk("b_alu1", {b_alu_x, b_alu_y, 2'b00}, {8'h94, 2'b00});
    chk("b_f1", {b_alu_f1, b_alu_f0}, 8'h01);
    tick();
    tick();

    // Reset in the middle of SETTLE
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", {b_busy, b_rsp0_valid, b_rsp1_valid, b_alu_f1, b_alu_f0}, 8'h00);
    chk("mid_rst_alu", {b_alu_x, b_alu_y}, 8'h00);
    chk("mid_rst_a_alu", {a_alu_x, a_alu_y}, 8'h00);
    tick();
    rst_n = 1'b1;
    b_rsp1_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_quiet", {b_busy, b_rsp0_valid, b_rsp1_valid}, 8'h00);
    end
    b_req0_valid = 1'b1;
    b_req1_valid = 1'b1; b_req1_op = 2'b00; b_req1_x = 4'd6; b_req1_y = 4'd7;
    #1;
    chk("post_rst_ptr0", {b_req1_ready, b_req0_ready}, 8'h01);
    b_req0_valid = 1'b0;
    #1;
    chk("post_rst_grant1", {b_req1_ready, b_req0_ready}, 8'h02);
    tick();
    b_req1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_settle", b_rsp1_valid, 8'h00);
    end
    tick();
    chk("post_rst_rsp", {3'b000, b_rsp1_valid, b_rsp1_data}, 8'h1D);
    tick();
    chk("post_rst_done", {b_busy, b_rsp1_valid}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
